// File: rtl/plat_pkg.sv
// Shared definitions for the platform scroll scheduler.
//   plat_state_t : sequencer states
//   plat_dbg_t   : debug view of the sequencer (state, slot counter, LFSR)
//   lfsr_step    : one step of the 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1
package plat_pkg;

   localparam int N_PLAT  = 16;
   localparam int SLOT_W  = $clog2(N_PLAT);
   localparam int COORD_W = 10;
   localparam int Y_MAX   = 479;
   localparam int X_MIN   = 40;
   localparam int SPACING = 30;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      RD,
      CALC,
      WR,
      DONE
   } plat_state_t;

   typedef struct packed {
      plat_state_t       state;
      logic [SLOT_W-1:0] slot;
      logic [15:0]       lfsr;
   } plat_dbg_t;

   // Right-shifting Galois form: the bit shifted out feeds taps 16,14,13,11.
   function automatic logic [15:0] lfsr_step(input logic [15:0] q);
      lfsr_step = q[0] ? ((q >> 1) ^ 16'hB400) : (q >> 1);
   endfunction

endpackage

// File: rtl/plat_lfsr16.sv
// Free-running 16-bit Galois LFSR used for platform respawn X positions.
// Ports:
//   Clk     in   system clock
//   Reset_n in   asynchronous active-low reset, loads the seed
//   seed    in   reset value; an all-zero seed is replaced by 1 (the LFSR would lock up)
//   q       out  current LFSR state, advances every Clk cycle
module plat_lfsr16
   import plat_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic [15:0] seed_safe;

   assign seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         q <= seed_safe;
      end else begin
         q <= lfsr_step(q);
      end
   end

endmodule

// File: rtl/plat_scroll_scheduler.sv
// Sequences the platform register file: initial layout fill and per-frame scroll passes.
// Platforms pushed past the bottom row respawn at the top with a pseudo-random X.
//
// Handshake: load_req and scroll_req are levels, sampled only on frame_tick while
// IDLE (load_req wins). The requester holds its level until done, a one-cycle
// completion pulse. Once a pass starts it runs to the end regardless of the request
// level or further frame ticks.
//
// Ports:
//   Clk, Reset_n        clock, asynchronous active-low reset
//   frame_tick          1-cycle pulse per video frame
//   load_req            request initial layout
//   scroll_req          request scroll pass
//   scroll_amt[7:0]     downward shift in pixels
//   rd_idx              register-file read slot; rd_x/rd_y valid one cycle later
//   rd_x, rd_y          register-file read data
//   wr_en, wr_idx       register-file write strobe and slot
//   wr_x, wr_y          register-file write data
//   busy                a pass is in progress
//   done                1-cycle pulse at the end of a pass
//   scroll_tot[15:0]    accumulated scroll distance, saturating
//   dbg                 state, slot counter and LFSR for observation
module plat_scroll_scheduler
   import plat_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               frame_tick,
   input  logic               load_req,
   input  logic               scroll_req,
   input  logic [7:0]         scroll_amt,
   output logic [SLOT_W-1:0]  rd_idx,
   input  logic [COORD_W-1:0] rd_x,
   input  logic [COORD_W-1:0] rd_y,
   output logic               wr_en,
   output logic [SLOT_W-1:0]  wr_idx,
   output logic [COORD_W-1:0] wr_x,
   output logic [COORD_W-1:0] wr_y,
   output logic               busy,
   output logic               done,
   output logic [15:0]        scroll_tot,
   output plat_dbg_t          dbg
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_PLAT - 1);

   plat_state_t        state, state_d;
   logic [SLOT_W-1:0]  slot, slot_d;
   logic [SLOT_W-1:0]  rd_idx_d;
   logic [7:0]         amt, amt_d;
   logic               is_scroll, is_scroll_d;
   logic [COORD_W-1:0] new_x, new_x_d;
   logic [COORD_W-1:0] new_y, new_y_d;
   logic [15:0]        scroll_tot_d;

   logic [15:0]        lfsr_q;
   logic [COORD_W-1:0] lfsr_x;
   logic [COORD_W-1:0] fill_y;
   logic [COORD_W:0]   sum;
   logic               wrap;
   logic [COORD_W-1:0] wrapped_y;
   logic [16:0]        tot_sum;
   logic [15:0]        tot_sat;

   plat_lfsr16 u_lfsr (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .seed    (SEED),
      .q       (lfsr_q)
   );

   assign lfsr_x = COORD_W'(X_MIN) + COORD_W'(lfsr_q[8:0]);

   // Initial layout: slot 0 sits SPACING above the bottom edge, slot N_PLAT-1 at row 0.
   assign fill_y = COORD_W'(Y_MAX + 1 - SPACING * (int'(slot) + 1));

   // One extra bit so a shift past the bottom row is visible before wrapping.
   assign sum       = {1'b0, rd_y} + (COORD_W+1)'(amt);
   assign wrap      = sum > (COORD_W+1)'(Y_MAX);
   assign wrapped_y = COORD_W'(sum - (COORD_W+1)'(Y_MAX + 1));

   assign tot_sum = {1'b0, scroll_tot} + 17'(amt);
   assign tot_sat = tot_sum[16] ? 16'hFFFF : tot_sum[15:0];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         slot       <= '0;
         rd_idx     <= '0;
         amt        <= '0;
         is_scroll  <= 1'b0;
         new_x      <= '0;
         new_y      <= '0;
         scroll_tot <= '0;
      end else begin
         state      <= state_d;
         slot       <= slot_d;
         rd_idx     <= rd_idx_d;
         amt        <= amt_d;
         is_scroll  <= is_scroll_d;
         new_x      <= new_x_d;
         new_y      <= new_y_d;
         scroll_tot <= scroll_tot_d;
      end
   end

   always_comb begin
      state_d      = state;
      slot_d       = slot;
      rd_idx_d     = rd_idx;
      amt_d        = amt;
      is_scroll_d  = is_scroll;
      new_x_d      = new_x;
      new_y_d      = new_y;
      scroll_tot_d = scroll_tot;
      wr_en        = 1'b0;
      wr_idx       = '0;
      wr_x         = '0;
      wr_y         = '0;
      busy         = (state != IDLE);
      done         = (state == DONE);

      case (state)
         IDLE: begin
            if (frame_tick) begin
               if (load_req) begin
                  state_d     = FILL;
                  slot_d      = '0;
                  is_scroll_d = 1'b0;
               end else if (scroll_req) begin
                  amt_d       = scroll_amt;
                  is_scroll_d = 1'b1;
                  slot_d      = '0;
                  if (scroll_amt == 8'd0) begin
                     state_d = DONE;
                  end else begin
                     state_d  = RD;
                     rd_idx_d = '0;
                  end
               end
            end
         end
         FILL: begin
            wr_en  = 1'b1;
            wr_idx = slot;
            wr_x   = lfsr_x;
            wr_y   = fill_y;
            if (slot == LAST_SLOT) begin
               state_d = DONE;
            end else begin
               slot_d = slot + SLOT_W'(1);
            end
         end
         RD: begin
            state_d = CALC;
         end
         CALC: begin
            if (wrap) begin
               new_y_d = wrapped_y;
               new_x_d = lfsr_x;
            end else begin
               new_y_d = sum[COORD_W-1:0];
               new_x_d = rd_x;
            end
            state_d = WR;
         end
         WR: begin
            wr_en  = 1'b1;
            wr_idx = slot;
            wr_x   = new_x;
            wr_y   = new_y;
            if (slot == LAST_SLOT) begin
               state_d = DONE;
            end else begin
               slot_d   = slot + SLOT_W'(1);
               rd_idx_d = slot + SLOT_W'(1);
               state_d  = RD;
            end
         end
         DONE: begin
            if (is_scroll) begin
               scroll_tot_d = tot_sat;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign dbg = '{state: state, slot: slot, lfsr: lfsr_q};

endmodule

// File: tb/tb_plat_scroll_scheduler.sv
// Directed bench for plat_scroll_scheduler: register-file model, LFSR reference,
// write/done monitor, expected-write queue and one task per scenario.
module tb_plat_scroll_scheduler;
   import plat_pkg::*;

   localparam int EXP_W = 1 + SLOT_W + 2 * COORD_W;   // {wrap, idx, x, y}

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT ----------------
   logic               frame_tick = 1'b0;
   logic               load_req = 1'b0;
   logic               scroll_req = 1'b0;
   logic [7:0]         scroll_amt = 8'd0;
   logic [SLOT_W-1:0]  rd_idx;
   logic [COORD_W-1:0] rd_x, rd_y;
   logic               wr_en;
   logic [SLOT_W-1:0]  wr_idx;
   logic [COORD_W-1:0] wr_x, wr_y;
   logic               busy, done;
   logic [15:0]        scroll_tot;
   plat_dbg_t          dbg;

   plat_scroll_scheduler #(.SEED(16'hACE1)) dut (
      .Clk        (clk),
      .Reset_n    (rst_n),
      .frame_tick (frame_tick),
      .load_req   (load_req),
      .scroll_req (scroll_req),
      .scroll_amt (scroll_amt),
      .rd_idx     (rd_idx),
      .rd_x       (rd_x),
      .rd_y       (rd_y),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_x       (wr_x),
      .wr_y       (wr_y),
      .busy       (busy),
      .done       (done),
      .scroll_tot (scroll_tot),
      .dbg        (dbg)
   );

   // ---------------- register file model with preload port ----------------
   logic [COORD_W-1:0] rf_x [N_PLAT];
   logic [COORD_W-1:0] rf_y [N_PLAT];
   logic               pl_en = 1'b0;
   logic [SLOT_W-1:0]  pl_idx = '0;
   logic [COORD_W-1:0] pl_x = '0, pl_y = '0;
   logic [COORD_W-1:0] pre_x [N_PLAT];
   logic [COORD_W-1:0] pre_y [N_PLAT];

   always @(posedge clk) begin
      if (pl_en) begin
         rf_x[pl_idx] <= pl_x;
         rf_y[pl_idx] <= pl_y;
      end else if (wr_en) begin
         rf_x[wr_idx] <= wr_x;
         rf_y[wr_idx] <= wr_y;
      end
      rd_x <= rf_x[rd_idx];
      rd_y <= rf_y[rd_idx];
   end

   // ---------------- LFSR reference (x^16+x^14+x^13+x^11+1, Galois) ----------------
   function automatic logic [15:0] ref_step(input logic [15:0] v);
      logic [15:0] s;
      s = {1'b0, v[15:1]};
      if (v[0]) s = s ^ 16'hB400;
      return s;
   endfunction

   logic [15:0] m_lfsr, m_lfsr_d;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lfsr   <= 16'hACE1;
         m_lfsr_d <= 16'hACE1;
      end else begin
         m_lfsr   <= ref_step(m_lfsr);
         m_lfsr_d <= m_lfsr;
      end
   end

   // ---------------- monitor ----------------
   typedef struct {
      int                 c;
      logic [SLOT_W-1:0]  idx;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [15:0]        l_now;
      logic [15:0]        l_prev;
   } wrec_t;

   wrec_t wlog[$];
   int    dlog[$];

   always @(negedge clk) begin
      if (wr_en === 1'b1) wlog.push_back('{cyc, wr_idx, wr_x, wr_y, m_lfsr, m_lfsr_d});
      if (done === 1'b1) dlog.push_back(cyc);
   end

   // ---------------- scoreboard ----------------
   logic [EXP_W-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass = 0;

   // ---------------- driver tasks ----------------
   task automatic pulse_frame(input logic ld, input logic sc, input logic [7:0] amt, output int p);
      @(negedge clk);
      load_req   = ld;
      scroll_req = sc;
      scroll_amt = amt;
      frame_tick = 1'b1;
      p = cyc;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (done === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic release_reqs;
      load_req   = 1'b0;
      scroll_req = 1'b0;
   endtask

   task automatic clear_logs;
      wlog.delete();
      dlog.delete();
   endtask

   task automatic preload_rf;
      for (int i = 0; i < N_PLAT; i++) begin
         @(negedge clk);
         pl_en  = 1'b1;
         pl_idx = SLOT_W'(i);
         pl_x   = pre_x[i];
         pl_y   = pre_y[i];
      end
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic build_exp(input int amt);
      int s;
      exp_q.delete();
      for (int i = 0; i < N_PLAT; i++) begin
         s = int'(pre_y[i]) + amt;
         if (s > 479) exp_q.push_back({1'b1, SLOT_W'(i), COORD_W'(0), COORD_W'(s - 480)});
         else         exp_q.push_back({1'b0, SLOT_W'(i), pre_x[i], COORD_W'(s)});
      end
   endtask

   task automatic check_scroll_writes(input string name, input int p);
      logic [EXP_W-1:0]   e;
      wrec_t              r;
      logic [COORD_W-1:0] ex;
      n_checks++;
      if (wlog.size() !== N_PLAT)
         $display("FAIL %s write_count got %0d want %0d", name, wlog.size(), N_PLAT);
      else n_pass++;
      for (int k = 0; k < N_PLAT && k < wlog.size() && exp_q.size() > 0; k++) begin
         r = wlog[k];
         e = exp_q.pop_front();
         ex = e[EXP_W-1] ? COORD_W'(40 + int'(r.l_prev[8:0])) : e[2*COORD_W-1:COORD_W];
         n_checks++;
         if (r.c !== p + 3 + 3 * k) $display("FAIL %s wr%0d_cycle got %0d want %0d", name, k, r.c, p + 3 + 3 * k);
         else n_pass++;
         n_checks++;
         if (r.idx !== e[EXP_W-2 -: SLOT_W]) $display("FAIL %s wr%0d_idx got %0d want %0d", name, k, r.idx, e[EXP_W-2 -: SLOT_W]);
         else n_pass++;
         n_checks++;
         if (r.y !== e[COORD_W-1:0]) $display("FAIL %s wr%0d_y got %0d want %0d", name, k, r.y, e[COORD_W-1:0]);
         else n_pass++;
         n_checks++;
         if (r.x !== ex) $display("FAIL %s wr%0d_x got %0d want %0d", name, k, r.x, ex);
         else n_pass++;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      int p;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if ({busy, done, wr_en} !== 3'b000) $display("FAIL reset_flags got %b want 000", {busy, done, wr_en}); else n_pass++;
      n_checks++; if (scroll_tot !== 16'd0) $display("FAIL reset_tot got %h want 0000", scroll_tot); else n_pass++;
      n_checks++; if (rd_idx !== '0) $display("FAIL reset_rd_idx got %0d want 0", rd_idx); else n_pass++;
      n_checks++; if (dbg.state !== IDLE) $display("FAIL reset_state got %0d want %0d", dbg.state, IDLE); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      clear_logs();
      pulse_frame(1'b1, 1'b0, 8'd0, p);
      repeat (4) @(negedge clk);
      n_checks++; if (busy !== 1'b1) $display("FAIL midfill_busy got %b want 1", busy); else n_pass++;
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if ({busy, done, wr_en} !== 3'b000) $display("FAIL midreset_flags got %b want 000", {busy, done, wr_en}); else n_pass++;
      n_checks++; if (dbg.state !== IDLE) $display("FAIL midreset_state got %0d want %0d", dbg.state, IDLE); else n_pass++;
      release_reqs();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (scroll_tot !== 16'd0) $display("FAIL midreset_tot got %h want 0000", scroll_tot); else n_pass++;
      n_checks++; if (dlog.size() !== 0) $display("FAIL midreset_done_pulses got %0d want 0", dlog.size()); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL after_reset_busy got %b want 0", busy); else n_pass++;
   endtask

   task automatic check_fill(input string name, input int p);
      wrec_t r;
      int    ey;
      n_checks++;
      if (wlog.size() !== N_PLAT) $display("FAIL %s write_count got %0d want %0d", name, wlog.size(), N_PLAT);
      else n_pass++;
      for (int k = 0; k < N_PLAT && k < wlog.size(); k++) begin
         r = wlog[k];
         ey = 480 - 30 * (k + 1);
         n_checks++; if (r.c !== p + 1 + k) $display("FAIL %s fill%0d_cycle got %0d want %0d", name, k, r.c, p + 1 + k); else n_pass++;
         n_checks++; if (r.idx !== SLOT_W'(k)) $display("FAIL %s fill%0d_idx got %0d want %0d", name, k, r.idx, k); else n_pass++;
         n_checks++; if (r.y !== COORD_W'(ey)) $display("FAIL %s fill%0d_y got %0d want %0d", name, k, r.y, ey); else n_pass++;
         n_checks++; if (r.x !== COORD_W'(40 + int'(r.l_now[8:0]))) $display("FAIL %s fill%0d_x got %0d want %0d", name, k, r.x, 40 + int'(r.l_now[8:0])); else n_pass++;
         n_checks++; if (r.x < 40 || r.x > 551) $display("FAIL %s fill%0d_x_range got %0d want 40..551", name, k, r.x); else n_pass++;
      end
      n_checks++;
      if (dlog.size() !== 1 || dlog[0] !== p + 17) $display("FAIL %s done_cycle got %0d pulses first %0d want 1 at %0d", name, dlog.size(), (dlog.size() > 0) ? dlog[0] : -1, p + 17);
      else n_pass++;
   endtask

   task automatic test_fill;
      int p; bit seen;
      clear_logs();
      pulse_frame(1'b1, 1'b0, 8'd0, p);
      wait_done(40, seen);
      n_checks++; if (!seen) $display("FAIL fill_done_timeout got 0 want 1"); else n_pass++;
      release_reqs();
      @(negedge clk);
      n_checks++; if (done !== 1'b0) $display("FAIL fill_done_width got %b want 0", done); else n_pass++;
      check_fill("fill", p);
      n_checks++; if (wlog.size() > 0 && wlog[0].y !== 10'd450) $display("FAIL fill_slot0_y got %0d want 450", wlog[0].y); else n_pass++;
      n_checks++; if (wlog.size() > 15 && wlog[15].y !== 10'd0) $display("FAIL fill_slot15_y got %0d want 0", wlog[15].y); else n_pass++;
      n_checks++; if (scroll_tot !== 16'd0) $display("FAIL fill_tot got %h want 0000", scroll_tot); else n_pass++;
   endtask

   task automatic run_scroll(input string name, input int amt, input logic [15:0] exp_tot);
      int p; bit seen;
      preload_rf();
      build_exp(amt);
      clear_logs();
      pulse_frame(1'b0, 1'b1, 8'(amt), p);
      wait_done(80, seen);
      n_checks++; if (!seen) $display("FAIL %s done_timeout got 0 want 1", name); else n_pass++;
      release_reqs();
      @(negedge clk);
      n_checks++; if (done !== 1'b0) $display("FAIL %s done_width got %b want 0", name, done); else n_pass++;
      check_scroll_writes(name, p);
      n_checks++;
      if (dlog.size() !== 1 || dlog[0] !== p + 49) $display("FAIL %s done_cycle got %0d pulses want 1 at %0d", name, dlog.size(), p + 49);
      else n_pass++;
      n_checks++; if (scroll_tot !== exp_tot) $display("FAIL %s tot got %h want %h", name, scroll_tot, exp_tot); else n_pass++;
   endtask

   task automatic test_scroll;
      for (int i = 0; i < N_PLAT; i++) begin
         pre_y[i] = COORD_W'(100 + 20 * i);
         pre_x[i] = COORD_W'(100 + 7 * i);
      end
      run_scroll("scroll10", 10, 16'd10);
   endtask

   task automatic test_wrap;
      for (int i = 0; i < N_PLAT; i++) begin
         pre_y[i] = COORD_W'(10 * i);
         pre_x[i] = COORD_W'(300 + i);
      end
      pre_y[0] = 10'd470;   // 490 -> 10, respawn
      pre_y[1] = 10'd459;   // 479 stays
      pre_y[2] = 10'd460;   // 480 -> 0, respawn
      pre_y[3] = 10'd479;   // 499 -> 19, respawn
      run_scroll("wrap20", 20, 16'd30);
   endtask

   task automatic test_both;
      int p; bit seen;
      clear_logs();
      pulse_frame(1'b1, 1'b1, 8'd50, p);
      wait_done(40, seen);
      n_checks++; if (!seen) $display("FAIL both_done_timeout got 0 want 1"); else n_pass++;
      release_reqs();
      @(negedge clk);
      check_fill("both", p);
      n_checks++; if (scroll_tot !== 16'd30) $display("FAIL both_tot got %h want %h", scroll_tot, 16'd30); else n_pass++;
   endtask

   task automatic test_zero_amt;
      int p;
      clear_logs();
      pulse_frame(1'b0, 1'b1, 8'd0, p);
      n_checks++; if ({done, busy, wr_en} !== 3'b110) $display("FAIL zero_flags got %b want 110", {done, busy, wr_en}); else n_pass++;
      release_reqs();
      @(negedge clk);
      n_checks++; if ({done, busy} !== 2'b00) $display("FAIL zero_after got %b want 00", {done, busy}); else n_pass++;
      repeat (5) @(negedge clk);
      n_checks++; if (wlog.size() !== 0) $display("FAIL zero_writes got %0d want 0", wlog.size()); else n_pass++;
      n_checks++;
      if (dlog.size() !== 1 || dlog[0] !== p + 1) $display("FAIL zero_done_cycle got %0d pulses want 1 at %0d", dlog.size(), p + 1);
      else n_pass++;
      n_checks++; if (scroll_tot !== 16'd30) $display("FAIL zero_tot got %h want %h", scroll_tot, 16'd30); else n_pass++;
   endtask

   task automatic test_busy_tick;
      int p; bit seen;
      for (int i = 0; i < N_PLAT; i++) begin
         pre_y[i] = COORD_W'(30 * i);
         pre_x[i] = COORD_W'(60 + i);
      end
      preload_rf();
      build_exp(5);
      clear_logs();
      pulse_frame(1'b0, 1'b1, 8'd5, p);
      repeat (4) @(negedge clk);
      scroll_req = 1'b0;                 // dropped mid-pass
      repeat (6) @(negedge clk);
      load_req   = 1'b1;                 // tick while busy
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      load_req   = 1'b0;
      wait_done(80, seen);
      n_checks++; if (!seen) $display("FAIL busy_done_timeout got 0 want 1"); else n_pass++;
      @(negedge clk);
      check_scroll_writes("busy_tick", p);
      repeat (20) @(negedge clk);
      n_checks++; if (wlog.size() !== N_PLAT) $display("FAIL busy_extra_writes got %0d want %0d", wlog.size(), N_PLAT); else n_pass++;
      n_checks++;
      if (dlog.size() !== 1 || dlog[0] !== p + 49) $display("FAIL busy_done_cycle got %0d pulses want 1 at %0d", dlog.size(), p + 49);
      else n_pass++;
      n_checks++; if (scroll_tot !== 16'd35) $display("FAIL busy_tot got %h want %h", scroll_tot, 16'd35); else n_pass++;
   endtask

   task automatic run_pass(input logic [7:0] amt, inout int timeouts);
      int p; bit seen;
      pulse_frame(1'b0, 1'b1, amt, p);
      wait_done(80, seen);
      if (!seen) timeouts++;
      release_reqs();
      @(negedge clk);
   endtask

   task automatic test_saturate;
      int to;
      to = 0;
      for (int i = 0; i < 256; i++) run_pass(8'd255, to);
      run_pass(8'd205, to);            // 35 + 256*255 + 205 = 0xFFF0
      n_checks++; if (scroll_tot !== 16'hFFF0) $display("FAIL sat_pre got %h want FFF0", scroll_tot); else n_pass++;
      run_pass(8'h20, to);
      n_checks++; if (scroll_tot !== 16'hFFFF) $display("FAIL sat_clip got %h want FFFF", scroll_tot); else n_pass++;
      run_pass(8'd1, to);
      n_checks++; if (scroll_tot !== 16'hFFFF) $display("FAIL sat_hold got %h want FFFF", scroll_tot); else n_pass++;
      n_checks++; if (to !== 0) $display("FAIL sat_timeouts got %0d want 0", to); else n_pass++;
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_fill();
      test_scroll();
      test_wrap();
      test_both();
      test_zero_amt();
      test_busy_tick();
      test_saturate();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
